// File: rtl/trap_entry_ctrl_pkg.sv
// Shared constants for the trap entry / xret controller: privilege encodings,
// owned CSR addresses, mstatus bit positions and the controller state type.
package trap_entry_ctrl_pkg;

  localparam logic [1:0] PRV_U = 2'd0;
  localparam logic [1:0] PRV_S = 2'd1;
  localparam logic [1:0] PRV_M = 2'd3;

  localparam logic [11:0] CSR_SSTATUS = 12'h100;
  localparam logic [11:0] CSR_SEPC    = 12'h141;
  localparam logic [11:0] CSR_SCAUSE  = 12'h142;
  localparam logic [11:0] CSR_STVAL   = 12'h143;
  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MTVAL   = 12'h343;

  localparam int MS_SIE    = 1;
  localparam int MS_MIE    = 3;
  localparam int MS_SPIE   = 5;
  localparam int MS_MPIE   = 7;
  localparam int MS_SPP    = 8;
  localparam int MS_MPP_LO = 11;
  localparam int MS_MPP_HI = 12;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REDIR = 2'd1,
    WAIT  = 2'd2
  } trap_state_e;

  // The reserved MPP encoding 2 (H) is not supported and collapses to U.
  function automatic logic [1:0] legal_mpp(input logic [1:0] v);
    return (v == 2'd2) ? PRV_U : v;
  endfunction

endpackage

// File: rtl/trap_entry_ctrl_vec.sv
// Combinational delegation decision and trap vector target for one trap request.
module trap_vec_calc
  import trap_entry_ctrl_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int ADDR_LEN = 32
) (
  input  logic [1:0]          i_prv,
  input  logic                i_intr,
  input  logic [4:0]          i_idx,
  input  logic [XLEN-1:0]     i_medeleg,
  input  logic [XLEN-1:0]     i_mideleg,
  input  logic [XLEN-1:0]     i_mtvec,
  input  logic [XLEN-1:0]     i_stvec,
  output logic                o_to_s,
  output logic [ADDR_LEN-1:0] o_target
);

  logic            w_deleg;
  logic [XLEN-1:0] w_tvec;
  logic [XLEN-1:0] w_base;
  logic [XLEN-1:0] w_vec;
  logic [XLEN-1:0] w_target;

  assign w_deleg = i_intr ? i_mideleg[i_idx] : i_medeleg[i_idx];
  // Traps taken in M never delegate downward.
  assign o_to_s  = (i_prv != PRV_M) && w_deleg;

  assign w_tvec   = o_to_s ? i_stvec : i_mtvec;
  assign w_base   = {w_tvec[XLEN-1:2], 2'b00};
  assign w_vec    = w_base + {{(XLEN-7){1'b0}}, i_idx, 2'b00};
  assign w_target = ((w_tvec[1:0] == 2'b01) && i_intr) ? w_vec : w_base;
  assign o_target = w_target[ADDR_LEN-1:0];

endmodule

// File: rtl/trap_entry_ctrl.sv
// Trap entry and mret/sret execution: owns privilege, xEPC/xCAUSE/xTVAL and the
// mstatus trap bits, issues a one-cycle redirect, then waits for the pipeline flush.
module trap_entry_ctrl
  import trap_entry_ctrl_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int ADDR_LEN = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_trap_en,
  input  logic [XLEN-1:0]     i_trap_cause,
  input  logic [ADDR_LEN-1:0] i_trap_epc,
  input  logic [XLEN-1:0]     i_trap_val,
  input  logic                i_mret,
  input  logic                i_sret,
  input  logic [XLEN-1:0]     i_medeleg,
  input  logic [XLEN-1:0]     i_mideleg,
  input  logic [XLEN-1:0]     i_mtvec,
  input  logic [XLEN-1:0]     i_stvec,
  input  logic                i_flush_done,
  input  logic                i_csr_we,
  input  logic [11:0]         i_csr_addr,
  input  logic [XLEN-1:0]     i_csr_wdata,
  output logic [1:0]          o_prv_cur,
  output logic [XLEN-1:0]     o_mstatus,
  output logic [XLEN-1:0]     o_mepc,
  output logic [XLEN-1:0]     o_mcause,
  output logic [XLEN-1:0]     o_mtval,
  output logic [XLEN-1:0]     o_sepc,
  output logic [XLEN-1:0]     o_scause,
  output logic [XLEN-1:0]     o_stval,
  output logic                o_redirect_en,
  output logic [ADDR_LEN-1:0] o_redirect_pc,
  output logic                o_busy,
  output logic [1:0]          o_state
);

  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_REDIR = REDIR;
  localparam logic [1:0] ST_WAIT  = WAIT;

  logic [1:0]          r_state;
  logic [1:0]          r_prv;
  logic                r_mie, r_mpie, r_sie, r_spie, r_spp;
  logic [1:0]          r_mpp;
  logic [XLEN-1:0]     r_mepc, r_mcause, r_mtval;
  logic [XLEN-1:0]     r_sepc, r_scause, r_stval;
  logic                r_redir_en;
  logic [ADDR_LEN-1:0] r_redir_pc;

  logic                w_idle;
  logic                w_take_trap, w_take_mret, w_take_sret;
  logic                w_to_s;
  logic [ADDR_LEN-1:0] w_vec_pc;
  logic [XLEN-1:0]     w_epc_al;

  // Events are only accepted in IDLE; trap_en beats mret beats sret.
  assign w_idle      = (r_state == ST_IDLE);
  assign w_take_trap = w_idle && i_trap_en;
  assign w_take_mret = w_idle && !i_trap_en && i_mret;
  assign w_take_sret = w_idle && !i_trap_en && !i_mret && i_sret;
  assign w_epc_al    = XLEN'(i_trap_epc & ~ADDR_LEN'(1));

  trap_vec_calc #(.XLEN(XLEN), .ADDR_LEN(ADDR_LEN)) u_vec (
    .i_prv     (r_prv),
    .i_intr    (i_trap_cause[XLEN-1]),
    .i_idx     (i_trap_cause[4:0]),
    .i_medeleg (i_medeleg),
    .i_mideleg (i_mideleg),
    .i_mtvec   (i_mtvec),
    .i_stvec   (i_stvec),
    .o_to_s    (w_to_s),
    .o_target  (w_vec_pc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_prv      <= PRV_M;
      r_mie      <= 1'b0;
      r_mpie     <= 1'b0;
      r_mpp      <= PRV_U;
      r_sie      <= 1'b0;
      r_spie     <= 1'b0;
      r_spp      <= 1'b0;
      r_mepc     <= '0;
      r_mcause   <= '0;
      r_mtval    <= '0;
      r_sepc     <= '0;
      r_scause   <= '0;
      r_stval    <= '0;
      r_redir_en <= 1'b0;
      r_redir_pc <= '0;
    end else begin
      // CSR writes land first so a same-edge trap/xret overrides only its own fields.
      if (i_csr_we) begin
        case (i_csr_addr)
          CSR_MSTATUS: begin
            r_mie  <= i_csr_wdata[MS_MIE];
            r_mpie <= i_csr_wdata[MS_MPIE];
            r_mpp  <= legal_mpp(i_csr_wdata[MS_MPP_HI:MS_MPP_LO]);
            r_sie  <= i_csr_wdata[MS_SIE];
            r_spie <= i_csr_wdata[MS_SPIE];
            r_spp  <= i_csr_wdata[MS_SPP];
          end
          CSR_SSTATUS: begin
            r_sie  <= i_csr_wdata[MS_SIE];
            r_spie <= i_csr_wdata[MS_SPIE];
            r_spp  <= i_csr_wdata[MS_SPP];
          end
          CSR_MEPC:   r_mepc   <= i_csr_wdata & ~XLEN'(1);
          CSR_MCAUSE: r_mcause <= i_csr_wdata;
          CSR_MTVAL:  r_mtval  <= i_csr_wdata;
          CSR_SEPC:   r_sepc   <= i_csr_wdata & ~XLEN'(1);
          CSR_SCAUSE: r_scause <= i_csr_wdata;
          CSR_STVAL:  r_stval  <= i_csr_wdata;
          default: ;
        endcase
      end

      case (r_state)
        ST_IDLE:  if (w_take_trap || w_take_mret || w_take_sret) r_state <= ST_REDIR;
        ST_REDIR: r_state <= ST_WAIT;
        ST_WAIT:  if (i_flush_done) r_state <= ST_IDLE;
        default:  r_state <= ST_IDLE;
      endcase

      r_redir_en <= 1'b0;
      if (w_take_trap) begin
        r_redir_en <= 1'b1;
        r_redir_pc <= w_vec_pc;
        if (w_to_s) begin
          r_sepc   <= w_epc_al;
          r_scause <= i_trap_cause;
          r_stval  <= i_trap_val;
          r_spie   <= r_sie;
          r_sie    <= 1'b0;
          r_spp    <= r_prv[0];
          r_prv    <= PRV_S;
        end else begin
          r_mepc   <= w_epc_al;
          r_mcause <= i_trap_cause;
          r_mtval  <= i_trap_val;
          r_mpie   <= r_mie;
          r_mie    <= 1'b0;
          r_mpp    <= r_prv;
          r_prv    <= PRV_M;
        end
      end else if (w_take_mret) begin
        r_redir_en <= 1'b1;
        r_redir_pc <= r_mepc[ADDR_LEN-1:0];
        r_prv      <= r_mpp;
        r_mie      <= r_mpie;
        r_mpie     <= 1'b1;
        r_mpp      <= PRV_U;
      end else if (w_take_sret) begin
        r_redir_en <= 1'b1;
        r_redir_pc <= r_sepc[ADDR_LEN-1:0];
        r_prv      <= {1'b0, r_spp};
        r_sie      <= r_spie;
        r_spie     <= 1'b1;
        r_spp      <= 1'b0;
      end
    end
  end

  always_comb begin
    o_mstatus            = '0;
    o_mstatus[MS_SIE]    = r_sie;
    o_mstatus[MS_MIE]    = r_mie;
    o_mstatus[MS_SPIE]   = r_spie;
    o_mstatus[MS_MPIE]   = r_mpie;
    o_mstatus[MS_SPP]    = r_spp;
    o_mstatus[MS_MPP_HI:MS_MPP_LO] = r_mpp;
  end

  assign o_prv_cur     = r_prv;
  assign o_mepc        = r_mepc;
  assign o_mcause      = r_mcause;
  assign o_mtval       = r_mtval;
  assign o_sepc        = r_sepc;
  assign o_scause      = r_scause;
  assign o_stval       = r_stval;
  assign o_redirect_en = r_redir_en;
  assign o_redirect_pc = r_redir_pc;
  assign o_busy        = !w_idle;
  assign o_state       = r_state;

endmodule

// File: tb/tb_trap_entry_ctrl.sv
// Directed + random bench for trap_entry_ctrl against a word-level behavioural model.
module tb_trap_entry_ctrl;

  localparam logic [31:0] MASK_M = 32'h0000_19AA;
  localparam logic [31:0] MASK_S = 32'h0000_0122;

  logic        clk = 1'b0;
  logic        rst;
  logic        trap_en, mret, sret, flush_done, csr_we;
  logic [31:0] trap_cause, trap_epc, trap_val;
  logic [31:0] medeleg, mideleg, mtvec, stvec, csr_wdata;
  logic [11:0] csr_addr;
  logic [1:0]  prv_cur, dbg_state;
  logic [31:0] mstatus_o, mepc_o, mcause_o, mtval_o, sepc_o, scause_o, stval_o;
  logic        redirect_en, busy;
  logic [31:0] redirect_pc;

  int total = 0;
  int bad = 0;

  logic [1:0]  m_prv;
  logic [31:0] m_ms, m_mepc, m_mcause, m_mtval, m_sepc, m_scause, m_stval, m_pc;
  logic        m_ren;
  int          m_phase;  // 0 free, 1 redirect cycle, 2 waiting for flush

  logic [11:0] addr_tab [9];

  trap_entry_ctrl dut (
    .clk(clk), .rst(rst),
    .i_trap_en(trap_en), .i_trap_cause(trap_cause), .i_trap_epc(trap_epc),
    .i_trap_val(trap_val), .i_mret(mret), .i_sret(sret),
    .i_medeleg(medeleg), .i_mideleg(mideleg), .i_mtvec(mtvec), .i_stvec(stvec),
    .i_flush_done(flush_done), .i_csr_we(csr_we), .i_csr_addr(csr_addr),
    .i_csr_wdata(csr_wdata),
    .o_prv_cur(prv_cur), .o_mstatus(mstatus_o), .o_mepc(mepc_o),
    .o_mcause(mcause_o), .o_mtval(mtval_o), .o_sepc(sepc_o),
    .o_scause(scause_o), .o_stval(stval_o), .o_redirect_en(redirect_en),
    .o_redirect_pc(redirect_pc), .o_busy(busy), .o_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_prv = 2'd3; m_ms = '0; m_mepc = '0; m_mcause = '0; m_mtval = '0;
    m_sepc = '0; m_scause = '0; m_stval = '0; m_pc = '0; m_ren = 1'b0; m_phase = 0;
  endtask

  task automatic model_edge();
    logic [31:0] o_ms, o_mepc, o_sepc, tvec, tgt;
    logic [1:0]  o_prv;
    logic        acc, intr, deleg, to_s;
    int          idx;
    o_ms = m_ms; o_mepc = m_mepc; o_sepc = m_sepc; o_prv = m_prv;
    acc = (m_phase == 0) && (trap_en || mret || sret);
    tgt = m_pc;
    if (csr_we) begin
      case (csr_addr)
        12'h300: begin
          m_ms = csr_wdata & MASK_M;
          if (m_ms[12:11] == 2'b10) m_ms[12:11] = 2'b00;
        end
        12'h100: m_ms = (m_ms & ~MASK_S) | (csr_wdata & MASK_S);
        12'h341: m_mepc = csr_wdata - (csr_wdata % 2);
        12'h342: m_mcause = csr_wdata;
        12'h343: m_mtval = csr_wdata;
        12'h141: m_sepc = csr_wdata - (csr_wdata % 2);
        12'h142: m_scause = csr_wdata;
        12'h143: m_stval = csr_wdata;
        default: ;
      endcase
    end
    if (acc && trap_en) begin
      intr  = trap_cause[31];
      idx   = int'(trap_cause % 32);
      deleg = intr ? mideleg[idx] : medeleg[idx];
      to_s  = (o_prv != 2'd3) && deleg;
      tvec  = to_s ? stvec : mtvec;
      tgt   = tvec - (tvec % 4);
      if (intr && (tvec % 4 == 1)) tgt = tgt + 32'(4 * idx);
      if (to_s) begin
        m_sepc = trap_epc - (trap_epc % 2); m_scause = trap_cause; m_stval = trap_val;
        m_ms[5] = o_ms[1]; m_ms[1] = 1'b0; m_ms[8] = o_prv[0]; m_prv = 2'd1;
      end else begin
        m_mepc = trap_epc - (trap_epc % 2); m_mcause = trap_cause; m_mtval = trap_val;
        m_ms[7] = o_ms[3]; m_ms[3] = 1'b0; m_ms[12:11] = o_prv; m_prv = 2'd3;
      end
    end else if (acc && mret) begin
      m_prv = o_ms[12:11]; m_ms[3] = o_ms[7]; m_ms[7] = 1'b1; m_ms[12:11] = 2'b00;
      tgt = o_mepc;
    end else if (acc && sret) begin
      m_prv = {1'b0, o_ms[8]}; m_ms[1] = o_ms[5]; m_ms[5] = 1'b1; m_ms[8] = 1'b0;
      tgt = o_sepc;
    end
    m_ren = acc;
    m_pc  = tgt;
    if (acc) m_phase = 1;
    else if (m_phase == 1) m_phase = 2;
    else if (m_phase == 2 && flush_done) m_phase = 0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_prv"}, 32'(prv_cur), 32'(m_prv));
    chk({tag, "_mstatus"}, mstatus_o, m_ms);
    chk({tag, "_mepc"}, mepc_o, m_mepc);
    chk({tag, "_mcause"}, mcause_o, m_mcause);
    chk({tag, "_mtval"}, mtval_o, m_mtval);
    chk({tag, "_sepc"}, sepc_o, m_sepc);
    chk({tag, "_scause"}, scause_o, m_scause);
    chk({tag, "_stval"}, stval_o, m_stval);
    chk({tag, "_ren"}, 32'(redirect_en), 32'(m_ren));
    chk({tag, "_rpc"}, redirect_pc, m_pc);
    chk({tag, "_busy"}, 32'(busy), 32'(m_phase != 0));
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic clear_inputs();
    trap_en = 0; mret = 0; sret = 0; flush_done = 0; csr_we = 0;
    trap_cause = '0; trap_epc = '0; trap_val = '0; csr_addr = '0; csr_wdata = '0;
  endtask

  task automatic csr_wr(input logic [11:0] a, input logic [31:0] d, input string tag);
    csr_we = 1; csr_addr = a; csr_wdata = d;
    tick(tag);
    csr_we = 0;
  endtask

  task automatic drain(input string tag);
    trap_en = 0; mret = 0; sret = 0;
    tick({tag, "_redir"});
    flush_done = 1;
    tick({tag, "_flush"});
    flush_done = 0;
  endtask

  task automatic do_trap(input logic [31:0] c, input logic [31:0] e, input logic [31:0] v, input string tag);
    trap_en = 1; trap_cause = c; trap_epc = e; trap_val = v;
    tick(tag);
    trap_en = 0;
  endtask

  initial begin
    addr_tab = '{12'h300, 12'h100, 12'h341, 12'h342, 12'h343, 12'h141, 12'h142, 12'h143, 12'h305};
    clear_inputs();
    medeleg = '0; mideleg = '0; mtvec = '0; stvec = '0;
    rst = 1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    chk("reset_prv_m", 32'(prv_cur), 32'd3);
    rst = 0;
    tick("idle0");

    // Enter U-mode through mret.
    csr_wr(12'h300, 32'h0, "ms0");
    csr_wr(12'h341, 32'h400, "mepc400");
    mret = 1; tick("mret_u"); mret = 0;
    chk("mret_u_pc", redirect_pc, 32'h400);
    chk("mret_u_prv", 32'(prv_cur), 32'd0);
    drain("mret_u");

    // U-mode delegated exception.
    medeleg = 32'h100; stvec = 32'h3000;
    do_trap(32'd8, 32'h1000, 32'h0, "t1");
    chk("t1_ren", 32'(redirect_en), 32'd1);
    chk("t1_pc", redirect_pc, 32'h3000);
    chk("t1_sepc", sepc_o, 32'h1000);
    chk("t1_scause", scause_o, 32'd8);
    chk("t1_prv", 32'(prv_cur), 32'd1);
    chk("t1_spp", 32'(mstatus_o[8]), 32'd0);
    drain("t1");

    medeleg = '0;
    do_trap(32'd3, 32'h44, 32'h0, "to_m");
    drain("to_m");

    // M-mode never delegates.
    csr_wr(12'h300, 32'h8, "mie1");
    medeleg = '1;
    do_trap(32'd2, 32'h50, 32'hDEAD, "t2");
    chk("t2_mtval", mtval_o, 32'hDEAD);
    chk("t2_prv", 32'(prv_cur), 32'd3);
    chk("t2_mpp", 32'(mstatus_o[12:11]), 32'd3);
    chk("t2_mie", 32'(mstatus_o[3]), 32'd0);
    chk("t2_mpie", 32'(mstatus_o[7]), 32'd1);
    drain("t2");

    // Vectored mode: only interrupts are offset.
    mtvec = 32'h8000_0001;
    do_trap(32'h8000_0007, 32'h60, 32'h0, "t3i");
    chk("t3i_pc", redirect_pc, 32'h8000_001C);
    drain("t3i");
    do_trap(32'd2, 32'h64, 32'h0, "t3e");
    chk("t3e_pc", redirect_pc, 32'h8000_0000);
    drain("t3e");

    csr_wr(12'h300, 32'h0000_1000, "mpp2");
    chk("mpp2_field", 32'(mstatus_o[12:11]), 32'd0);

    csr_wr(12'h300, 32'h80, "t4_ms");
    csr_wr(12'h341, 32'h2000, "t4_mepc");
    mret = 1; tick("t4"); mret = 0;
    chk("t4_prv", 32'(prv_cur), 32'd0);
    chk("t4_mie", 32'(mstatus_o[3]), 32'd1);
    chk("t4_mpp", 32'(mstatus_o[12:11]), 32'd0);
    chk("t4_pc", redirect_pc, 32'h2000);
    drain("t4");

    // Trap beats mret; later requests are ignored while busy.
    medeleg = '0; mtvec = 32'h100;
    trap_en = 1; mret = 1; trap_cause = 32'd5; trap_epc = 32'h2222;
    tick("t5_acc");
    chk("t5_pc", redirect_pc, 32'h100);
    chk("t5_prv", 32'(prv_cur), 32'd3);
    chk("t5_mepc", mepc_o, 32'h2222);
    mret = 0; trap_cause = 32'd6; flush_done = 1;
    tick("t5_redir");
    flush_done = 0;
    tick("t5_wait1");
    chk("t5_busy", 32'(busy), 32'd1);
    chk("t5_mcause", mcause_o, 32'd5);
    tick("t5_wait2");
    trap_en = 0; flush_done = 1;
    tick("t5_done");
    chk("t5_idle", 32'(busy), 32'd0);
    flush_done = 0;

    // Asynchronous reset while waiting for the flush.
    do_trap(32'd1, 32'h70, 32'h0, "t6");
    tick("t6_wait");
    #2 rst = 1;
    #1;
    model_reset();
    chk("t6_prv", 32'(prv_cur), 32'd3);
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_ren", 32'(redirect_en), 32'd0);
    #1 rst = 0;
    tick("t6_after");

    csr_wr(12'h100, 32'hFFFF_FFFF, "sstatus");
    chk("sstatus_mask", mstatus_o, 32'h122);
    csr_wr(12'h341, 32'h1235, "mepc_b0");
    chk("mepc_b0", mepc_o, 32'h1234);

    for (int i = 0; i < 600; i++) begin
      trap_en    = ($urandom_range(0, 5) == 0);
      mret       = ($urandom_range(0, 6) == 0);
      sret       = ($urandom_range(0, 6) == 0);
      flush_done = ($urandom_range(0, 2) == 0);
      csr_we     = ($urandom_range(0, 3) == 0);
      csr_addr   = addr_tab[$urandom_range(0, 8)];
      csr_wdata  = $urandom;
      trap_cause = $urandom;
      trap_epc   = $urandom;
      trap_val   = $urandom;
      medeleg    = $urandom;
      mideleg    = $urandom;
      mtvec      = $urandom;
      stvec      = $urandom;
      tick("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
